// File: rtl/cpu_bus_arbiter_pkg.sv
// Shared constants and types for the CPU bus arbiter.
// Size, request, response codes and FSM state encodings.
package cpu_bus_arbiter_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_D = 2'b11;

  localparam logic [1:0] REQ_READ  = 2'b00;
  localparam logic [1:0] REQ_WRITE = 2'b01;

  localparam logic [1:0] RESP_OKAY     = 2'b00;
  localparam logic [1:0] RESP_SLVERR   = 2'b10;
  localparam logic [1:0] RESP_MISALIGN = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE
  } state_e;

  typedef enum logic {
    GNT_IF,
    GNT_MEM
  } grant_e;

  // Contiguous low-lane mask covering one access of the given size.
  function automatic logic [7:0] size_lanes(input logic [1:0] size);
    logic [8:0] top;
    top = 9'd1 << (4'd1 << size);
    return 8'(top - 9'd1);
  endfunction

endpackage

// File: rtl/bus_lane_align.sv
// Byte-lane steering for the 64-bit bus.
// Positions write data/strobes and right-justifies read data.
module bus_lane_align
  import cpu_bus_arbiter_pkg::*;
(
  input  logic [2:0]  addr,
  input  logic [1:0]  size,
  input  logic [63:0] wdata_i,
  input  logic [63:0] rdata_i,
  output logic [63:0] wdata_o,
  output logic [7:0]  wstrb,
  output logic [63:0] rdata_o,
  output logic        misaligned
);

  logic [5:0]  sh;
  logic [2:0]  amask;
  logic [63:0] rmask;

  assign sh = {addr, 3'b000};

  always_comb begin
    amask = 3'd0;
    rmask = 64'hFF;
    unique case (size)
      SZ_B: begin
        amask = 3'd0;
        rmask = 64'hFF;
      end
      SZ_H: begin
        amask = 3'd1;
        rmask = 64'hFFFF;
      end
      SZ_W: begin
        amask = 3'd3;
        rmask = 64'hFFFF_FFFF;
      end
      SZ_D: begin
        amask = 3'd7;
        rmask = '1;
      end
    endcase
  end

  assign wdata_o    = wdata_i << sh;
  assign wstrb      = size_lanes(size) << addr;
  assign rdata_o    = (rdata_i >> sh) & rmask;
  assign misaligned = |(addr & amask);

endmodule

// File: rtl/cpu_bus_arbiter.sv
// Fetch/data port arbiter serialising one access at a time
// onto the external memory bus.
module cpu_bus_arbiter
  import cpu_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_valid,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic [1:0]        if_size,
  output logic              if_ready,
  output logic [1:0]        if_resp,
  output logic [DATA_W-1:0] if_data_read,
  input  logic              mem_valid,
  input  logic [1:0]        mem_req,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data_write,
  input  logic [1:0]        mem_size,
  output logic              mem_ready,
  output logic [1:0]        mem_resp,
  output logic [DATA_W-1:0] mem_data_read,
  output logic              bus_req_valid,
  input  logic              bus_req_ready,
  output logic              bus_req_write,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  output logic [7:0]        bus_wstrb,
  output logic [1:0]        bus_size,
  input  logic              bus_rsp_valid,
  input  logic [DATA_W-1:0] bus_rsp_data,
  input  logic              bus_rsp_err
);

  state_e            state_q, state_d;
  grant_e            grant_q, grant_d;
  grant_e            last_q, last_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [1:0]        size_q, size_d;
  logic [1:0]        resp_q, resp_d;
  logic              write_q, write_d;

  logic              pick_mem;
  logic              mis;
  logic              done_if;
  logic              done_mem;
  logic [DATA_W-1:0] al_wdata;
  logic [DATA_W-1:0] al_rdata;
  logic [7:0]        al_wstrb;

  bus_lane_align u_align (
    .addr       (addr_q[2:0]),
    .size       (size_q),
    .wdata_i    (wdata_q),
    .rdata_i    (bus_rsp_data),
    .wdata_o    (al_wdata),
    .wstrb      (al_wstrb),
    .rdata_o    (al_rdata),
    .misaligned (mis)
  );

  // On a tie the port that did not win last time goes next.
  assign pick_mem = mem_valid & (~if_valid | (last_q == GNT_IF));

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    size_d  = size_q;
    resp_d  = resp_q;
    write_d = write_q;
    unique case (state_q)
      ST_IDLE: begin
        if (if_valid | mem_valid) begin
          state_d = ST_ISSUE;
          unique case (1'b1)
            pick_mem: begin
              grant_d = GNT_MEM;
              addr_d  = mem_addr;
              size_d  = mem_size;
              write_d = (mem_req == REQ_WRITE);
              wdata_d = mem_data_write;
            end
            default: begin
              grant_d = GNT_IF;
              addr_d  = if_addr;
              size_d  = if_size;
              write_d = 1'b0;
              wdata_d = '0;
            end
          endcase
        end
      end
      ST_ISSUE: begin
        if (mis) begin
          resp_d  = RESP_MISALIGN;
          rdata_d = '0;
          state_d = ST_DONE;
        end else if (bus_req_ready) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (bus_rsp_valid) begin
          rdata_d = al_rdata;
          resp_d  = bus_rsp_err ? RESP_SLVERR : RESP_OKAY;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        last_d  = grant_q;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      grant_q <= GNT_IF;
      last_q  <= GNT_IF;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      size_q  <= '0;
      resp_q  <= '0;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      size_q  <= size_d;
      resp_q  <= resp_d;
      write_q <= write_d;
    end
  end

  assign done_if  = (state_q == ST_DONE) && (grant_q == GNT_IF);
  assign done_mem = (state_q == ST_DONE) && (grant_q == GNT_MEM);

  assign if_ready      = done_if;
  assign if_resp       = done_if ? resp_q : 2'b00;
  assign if_data_read  = done_if ? rdata_q : '0;
  assign mem_ready     = done_mem;
  assign mem_resp      = done_mem ? resp_q : 2'b00;
  assign mem_data_read = done_mem ? rdata_q : '0;

  assign bus_req_valid = (state_q == ST_ISSUE) && !mis;
  assign bus_req_write = write_q;
  assign bus_addr      = addr_q;
  assign bus_wdata     = al_wdata;
  assign bus_wstrb     = write_q ? al_wstrb : 8'h00;
  assign bus_size      = size_q;

endmodule
